// File: rtl/hazard_fwd_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_hazard_pkg
// Shared types and constants for the hazard / forwarding unit.
//   inflight_t  : shadow record of one instruction still in EX..WB
//   BUBBLE      : empty shadow record (never matches a source)
//   DEF_REG_W   : register-number width for the default 32-entry register file
//   DST_W       : storage width of the dst field, wide enough for up to
//                 256 architectural registers; narrower numbers are zero-extended
//   isReady()   : whether a matching writer can already supply its result
// ---------------------------------------------------------------------------
package cpu_hazard_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_REG_W    = $clog2(DEF_NUM_REGS);
    localparam int DST_W        = 8;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic [DST_W-1:0] dst;
        logic             is_load;
    } inflight_t;

    localparam inflight_t BUBBLE = '0;

    // A load only has its data once it reaches loadStage; everything else
    // has its result from EX onwards.
    function automatic logic isReady(input logic isLoad, input int stage, input int loadStage);
        return !isLoad || (stage >= loadStage);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_inflight_pipe.sv
// ---------------------------------------------------------------------------
// hazard_inflight_pipe
// Shadow shift register mirroring the EX..WB pipeline: one inflight_t per
// stage, index 0 = youngest (EX).
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset, clears every entry
//   i_hold     freeze all entries (external pipeline stall)
//   i_ins      record entering stage 0 (caller supplies BUBBLE when needed)
//   o_stages   current contents of all stages
// ---------------------------------------------------------------------------
module hazard_inflight_pipe
    import cpu_hazard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_hold,
    input  inflight_t                  i_ins,
    output inflight_t [PIPE_DEPTH-1:0] o_stages
);

    inflight_t [PIPE_DEPTH-1:0] r_stages;

    // Everything moves one stage older each cycle unless the pipeline is
    // frozen; the oldest entry falls off the end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_stages[k] <= BUBBLE;
            end
        end else if (!i_hold) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                r_stages[k] <= r_stages[k-1];
            end
            r_stages[0] <= i_ins;
        end
    end

    assign o_stages = r_stages;

endmodule

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Tracks in-flight register writers after ID, forwards the youngest ready
// result to each source operand and raises load-use / external stalls.
// Optional feature macro: HAZ_PERF_CNT_EN (adds o_stall_cnt stall counter).
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_id_valid         ID holds a real instruction
//   i_id_src           NUM_SRC packed source register numbers
//   i_id_src_used      per-source "actually read" flag
//   i_id_rf_data       NUM_SRC packed register-file read values
//   i_id_wr            ID instruction writes a register
//   i_id_dst           its destination register
//   i_id_is_load       destination written from memory
//   i_stg_data         PIPE_DEPTH packed results (index 0 = EX)
//   i_stall_in         external freeze
//   i_flush_in         kill the ID instruction
//   o_stall            hold PC, IF/ID and ID
//   o_fwd_hit          per-source "taken from a stage"
//   o_fwd_data         NUM_SRC packed final operand values
//   o_stall_cnt        stall-cycle counter (HAZ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module hazard_fwd_unit
    import cpu_hazard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_SRC    = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_STAGE = 2,
    localparam int REG_W     = $clog2(NUM_REGS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_id_valid,
    input  logic [NUM_SRC*REG_W-1:0]     i_id_src,
    input  logic [NUM_SRC-1:0]           i_id_src_used,
    input  logic [NUM_SRC*DATA_W-1:0]    i_id_rf_data,
    input  logic                         i_id_wr,
    input  logic [REG_W-1:0]             i_id_dst,
    input  logic                         i_id_is_load,
    input  logic [PIPE_DEPTH*DATA_W-1:0] i_stg_data,
    input  logic                         i_stall_in,
    input  logic                         i_flush_in,
    output logic                         o_stall,
    output logic [NUM_SRC-1:0]           o_fwd_hit,
    output logic [NUM_SRC*DATA_W-1:0]    o_fwd_data
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                  o_stall_cnt
`endif
);

    inflight_t [PIPE_DEPTH-1:0] w_stages;
    inflight_t                  w_ins;
    logic [NUM_SRC-1:0]         w_pend;
    logic                       w_loadUse;

    hazard_inflight_pipe #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_pipe (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_hold   (i_stall_in),
        .i_ins    (w_ins),
        .o_stages (w_stages)
    );

    // Per-source search. Stage 0 is scanned first so the youngest writer
    // always wins; if that writer is a load not yet at LOAD_STAGE the source
    // is pending even when an older stage could supply a (stale) value.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [DST_W-1:0]  w_src;
        logic              w_found;
        logic              w_ready;
        logic [DATA_W-1:0] w_stgVal;
        logic              w_hitS;

        always_comb begin
            w_src              = '0;
            w_src[REG_W-1:0]   = i_id_src[s*REG_W +: REG_W];
            w_found            = 1'b0;
            w_ready            = 1'b0;
            w_stgVal           = '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (!w_found && w_stages[k].valid && w_stages[k].wr &&
                    (w_stages[k].dst == w_src)) begin
                    w_found  = 1'b1;
                    w_ready  = isReady(w_stages[k].is_load, k, LOAD_STAGE);
                    w_stgVal = i_stg_data[k*DATA_W +: DATA_W];
                end
            end
        end

        assign w_hitS       = i_id_src_used[s] && w_found && w_ready;
        assign w_pend[s]    = i_id_src_used[s] && w_found && !w_ready;
        assign o_fwd_hit[s] = w_hitS;
        assign o_fwd_data[s*DATA_W +: DATA_W] =
            w_hitS ? w_stgVal : i_id_rf_data[s*DATA_W +: DATA_W];
    end

    assign w_loadUse = i_id_valid && !i_flush_in && (|w_pend);
    assign o_stall   = i_stall_in || w_loadUse;

    // Record entering EX: a bubble whenever ID does not really issue.
    always_comb begin
        w_ins = BUBBLE;
        if (i_id_valid && !i_flush_in && !w_loadUse) begin
            w_ins.valid              = 1'b1;
            w_ins.wr                 = i_id_wr;
            w_ins.dst[REG_W-1:0]     = i_id_dst;
            w_ins.is_load            = i_id_is_load;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stallCnt;

    // Counts every cycle the front end is held; wraps naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stallCnt <= '0;
        end else if (o_stall) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Directed scenarios followed by a randomized stream, all compared against a
// history-based reference: the model remembers which instruction was issued
// how many cycles ago and answers "who last wrote this register" directly.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_W      = 5;
    localparam int NUM_SRC    = 2;
    localparam int PIPE_DEPTH = 3;
    localparam int LOAD_STAGE = 2;

    logic                         clk = 1'b0;
    logic                         rstN;
    logic                         idValid;
    logic [NUM_SRC*REG_W-1:0]     idSrc;
    logic [NUM_SRC-1:0]           idSrcUsed;
    logic [NUM_SRC*DATA_W-1:0]    idRfData;
    logic                         idWr;
    logic [REG_W-1:0]             idDst;
    logic                         idIsLoad;
    logic [PIPE_DEPTH*DATA_W-1:0] stgData;
    logic                         stallIn;
    logic                         flushIn;
    logic                         stallO;
    logic [NUM_SRC-1:0]           fwdHit;
    logic [NUM_SRC*DATA_W-1:0]    fwdData;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]                  stallCnt;
`endif

    hazard_fwd_unit #(
        .DATA_W     (DATA_W),
        .NUM_REGS   (NUM_REGS),
        .NUM_SRC    (NUM_SRC),
        .PIPE_DEPTH (PIPE_DEPTH),
        .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_id_valid    (idValid),
        .i_id_src      (idSrc),
        .i_id_src_used (idSrcUsed),
        .i_id_rf_data  (idRfData),
        .i_id_wr       (idWr),
        .i_id_dst      (idDst),
        .i_id_is_load  (idIsLoad),
        .i_stg_data    (stgData),
        .i_stall_in    (stallIn),
        .i_flush_in    (flushIn),
        .o_stall       (stallO),
        .o_fwd_hit     (fwdHit),
        .o_fwd_data    (fwdData)
`ifdef HAZ_PERF_CNT_EN
        ,
        .o_stall_cnt   (stallCnt)
`endif
    );

    always #5 clk = ~clk;

    // Issued-instruction history: issued[a] is what ID issued a cycles ago
    // (still alive in the pipeline), or an empty slot.
    typedef struct {
        bit valid;
        bit wr;
        int dst;
        bit isLoad;
    } issued_t;

    issued_t                   issued[PIPE_DEPTH];
    bit                        expStall;
    bit                        expLoadUse;
    logic [NUM_SRC-1:0]        expHit;
    logic [NUM_SRC*DATA_W-1:0] expData;
    logic [31:0]               expCnt;
    int                        total = 0;
    int                        bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the current inputs, from the issue history.
    function automatic void computeModel();
        bit pending = 0;
        expHit  = '0;
        expData = idRfData;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (idSrcUsed[s]) begin
                int src = int'(idSrc[s*REG_W +: REG_W]);
                for (int a = 0; a < PIPE_DEPTH; a++) begin
                    if (issued[a].valid && issued[a].wr && issued[a].dst == src) begin
                        if (issued[a].isLoad && a < LOAD_STAGE) begin
                            pending = 1;
                        end else begin
                            expHit[s] = 1'b1;
                            expData[s*DATA_W +: DATA_W] = stgData[a*DATA_W +: DATA_W];
                        end
                        break;
                    end
                end
            end
        end
        expLoadUse = idValid && !flushIn && pending;
        expStall   = stallIn || expLoadUse;
    endfunction

    task automatic applyStimulus(input bit rst, input bit v, input int s0, input int s1,
                                 input bit [1:0] used, input bit wr, input int dst,
                                 input bit ld, input bit stl, input bit fl);
        rstN      = rst;
        idValid   = v;
        idSrc     = {REG_W'(s1), REG_W'(s0)};
        idSrcUsed = used;
        idWr      = wr;
        idDst     = REG_W'(dst);
        idIsLoad  = ld;
        stallIn   = stl;
        flushIn   = fl;
        idRfData  = {$urandom, $urandom};
        stgData   = {$urandom, $urandom, $urandom};
    endtask

    task automatic checkOutput(input string tag);
        @(negedge clk);
        computeModel();
        chk({tag, "_stall"}, 64'(stallO), 64'(expStall));
        chk({tag, "_hit"}, 64'(fwdHit), 64'(expHit));
        chk({tag, "_data"}, 64'(fwdData), 64'(expData));
`ifdef HAZ_PERF_CNT_EN
        chk({tag, "_cnt"}, 64'(stallCnt), 64'(expCnt));
`endif
    endtask

    // Clock edge: the history ages by one cycle unless frozen.
    task automatic advance();
        @(posedge clk);
        computeModel();
        if (!rstN) begin
            for (int a = 0; a < PIPE_DEPTH; a++) issued[a] = '{0, 0, 0, 0};
            expCnt = '0;
        end else begin
            if (expStall) expCnt = expCnt + 32'd1;
            if (!stallIn) begin
                for (int a = PIPE_DEPTH - 1; a > 0; a--) issued[a] = issued[a-1];
                if (idValid && !flushIn && !expLoadUse)
                    issued[0] = '{1, idWr, int'(idDst), idIsLoad};
                else
                    issued[0] = '{0, 0, 0, 0};
            end
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] cntStart;
        logic [31:0] rfWord;
        bit          resolved;

        for (int a = 0; a < PIPE_DEPTH; a++) issued[a] = '{0, 0, 0, 0};
        expCnt = '0;

        // Reset for two cycles, then check the cleared state.
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        advance();
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        advance();
        applyStimulus(1, 1, 3, 4, 2'b11, 0, 0, 0, 0, 0);
        checkOutput("reset");
        chk("reset_hit_zero", 64'(fwdHit), 64'd0);
        chk("reset_stall_zero", 64'(stallO), 64'd0);
        advance();

        // 1: ADD x3 then SUB x4,x3,x1 -> forwarded from EX.
        $display("[TB] scenario 1: back-to-back ALU forward");
        applyStimulus(1, 1, 1, 2, 2'b11, 1, 3, 0, 0, 0);
        checkOutput("t1_add");
        advance();
        applyStimulus(1, 1, 3, 1, 2'b11, 1, 4, 0, 0, 0);
        checkOutput("t1_sub");
        chk("t1_hit0", 64'(fwdHit[0]), 64'd1);
        chk("t1_data0", 64'(fwdData[DATA_W-1:0]), 64'(stgData[DATA_W-1:0]));
        chk("t1_nostall", 64'(stallO), 64'd0);
        advance();

        // 2: LW x5 then ADD x6,x5,x5 -> stall until the load is ready.
        $display("[TB] scenario 2: load-use");
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 5, 1, 0, 0);
        checkOutput("t2_lw");
        advance();
        applyStimulus(1, 1, 5, 5, 2'b11, 1, 6, 0, 0, 0);
        checkOutput("t2_add_first");
        chk("t2_stall_first", 64'(stallO), 64'd1);
        advance();
        resolved = 0;
        for (int i = 0; i < 4 && !resolved; i++) begin
            applyStimulus(1, 1, 5, 5, 2'b11, 1, 6, 0, 0, 0);
            checkOutput("t2_add_retry");
            if (!stallO) begin
                resolved = 1;
                chk("t2_both_hit", 64'(fwdHit), 64'b11);
            end
            advance();
        end
        chk("t2_resolved", 64'(resolved), 64'd1);

        // 3: two writers of x7 in flight -> the younger one wins.
        $display("[TB] scenario 3: youngest writer wins");
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 7, 0, 0, 0);
        checkOutput("t3_a");
        advance();
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checkOutput("t3_nop");
        advance();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 7, 0, 0, 0);
        checkOutput("t3_b");
        advance();
        applyStimulus(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        stgData[2*DATA_W +: DATA_W] = 32'h11;
        stgData[0 +: DATA_W]        = 32'h22;
        checkOutput("t3_read");
        chk("t3_value", 64'(fwdData[DATA_W-1:0]), 64'h22);
        advance();

        // 4: external stall holds a load in EX for three cycles.
        $display("[TB] scenario 4: external stall freeze");
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 8, 1, 0, 0);
        checkOutput("t4_lw");
        advance();
        cntStart = expCnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
            checkOutput("t4_hold");
            chk("t4_stall_hold", 64'(stallO), 64'd1);
            advance();
        end
        applyStimulus(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 0);
        checkOutput("t4_after");
        chk("t4_load_still_ex", 64'(stallO), 64'd1);
`ifdef HAZ_PERF_CNT_EN
        chk("t4_cnt3", 64'(stallCnt), 64'(cntStart + 32'd3));
`endif
        advance();

        // 5: flushed writer must never forward.
        $display("[TB] scenario 5: flush");
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 9, 0, 0, 1);
        checkOutput("t5_flush");
        advance();
        applyStimulus(1, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
        rfWord = idRfData[DATA_W-1:0];
        checkOutput("t5_read");
        chk("t5_nohit", 64'(fwdHit[0]), 64'd0);
        chk("t5_rfdata", 64'(fwdData[DATA_W-1:0]), 64'(rfWord));
        advance();

        // 6: reset mid-stream drops all in-flight writers.
        $display("[TB] scenario 6: reset mid-stream");
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 10, 0, 0, 0);
        checkOutput("t6_w1");
        advance();
        applyStimulus(1, 1, 0, 0, 2'b00, 1, 11, 1, 0, 0);
        checkOutput("t6_w2");
        advance();
        applyStimulus(0, 1, 10, 11, 2'b11, 0, 0, 0, 0, 0);
        checkOutput("t6_in_reset");
        advance();
        applyStimulus(1, 1, 10, 11, 2'b11, 0, 0, 0, 0, 0);
        checkOutput("t6_after");
        chk("t6_hit_zero", 64'(fwdHit), 64'd0);
        chk("t6_stall_zero", 64'(stallO), 64'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("t6_cnt_zero", 64'(stallCnt), 64'd0);
`endif
        advance();

        // Randomized stream over a small register set for frequent hazards.
        $display("[TB] randomized stream");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 3),
                          $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0);
            checkOutput("rand");
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
